// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the pipelined MIPS main control.
// Contents:
//   OP_*        6-bit opcode constants
//   alu_op_e    3-bit ALU operation selector driven to EX
//   ex_ctrl_t   controls held in ID/EX
//   mem_ctrl_t  controls held in EX/MEM
//   wb_ctrl_t   controls held in MEM/WB
//   ctrl_t      full decoded bundle produced in ID
//   BUBBLE / EX_BUBBLE  all-zero bundles used for stall/flush/reset slots
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic    alu_src;
    logic    branch;
    logic    branch_ne;
    logic    link;
    alu_op_e alu_op;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
    logic link;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic link;
  } wb_ctrl_t;

  // valid: the opcode was recognised (an unknown opcode decodes to BUBBLE,
  // which also forces the destination register to 0).
  // reads_rt: the instruction sources rt, so rt takes part in hazard checks.
  typedef struct packed {
    logic     valid;
    logic     reg_dst;
    logic     jump;
    logic     reads_rt;
    ex_ctrl_t ex;
  } ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '0;
  localparam ctrl_t    BUBBLE    = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder for the ID stage.
// Ports:
//   op    in   6-bit opcode of the instruction in ID
//   ctrl  out  decoded control bundle (BUBBLE for unknown/disabled opcodes)
// Parameters EN_IMM / EN_BNE / EN_JAL gate the optional instruction subsets;
// a disabled opcode decodes exactly like an unknown one.
module ctrl_decoder
  import mips_ctrl_pkg::*;
#(
  parameter bit EN_IMM = 1'b1,
  parameter bit EN_BNE = 1'b1,
  parameter bit EN_JAL = 1'b1
) (
  input  logic [5:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: every field gets a default before the case so that no path
    // leaves a bit unassigned; an incomplete assignment here infers a latch.
    ctrl = BUBBLE;
    case (op)
      OP_RTYPE: begin
        ctrl.valid        = 1'b1;
        ctrl.reg_dst      = 1'b1;
        ctrl.reads_rt     = 1'b1;
        ctrl.ex.reg_write = 1'b1;
        ctrl.ex.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        ctrl.valid         = 1'b1;
        ctrl.ex.alu_src    = 1'b1;
        ctrl.ex.mem_read   = 1'b1;
        ctrl.ex.mem_to_reg = 1'b1;
        ctrl.ex.reg_write  = 1'b1;
        ctrl.ex.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.valid        = 1'b1;
        ctrl.reads_rt     = 1'b1;
        ctrl.ex.alu_src   = 1'b1;
        ctrl.ex.mem_write = 1'b1;
        ctrl.ex.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.valid     = 1'b1;
        ctrl.reads_rt  = 1'b1;
        ctrl.ex.branch = 1'b1;
        ctrl.ex.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        if (EN_BNE) begin
          ctrl.valid        = 1'b1;
          ctrl.reads_rt     = 1'b1;
          ctrl.ex.branch    = 1'b1;
          ctrl.ex.branch_ne = 1'b1;
          ctrl.ex.alu_op    = ALU_SUB;
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        if (EN_IMM) begin
          ctrl.valid        = 1'b1;
          ctrl.ex.alu_src   = 1'b1;
          ctrl.ex.reg_write = 1'b1;
          case (op)
            OP_ANDI: ctrl.ex.alu_op = ALU_AND;
            OP_ORI:  ctrl.ex.alu_op = ALU_OR;
            OP_SLTI: ctrl.ex.alu_op = ALU_SLT;
            default: ctrl.ex.alu_op = ALU_ADD;
          endcase
        end
      end
      OP_J: begin
        ctrl.valid = 1'b1;
        ctrl.jump  = 1'b1;
      end
      OP_JAL: begin
        if (EN_JAL) begin
          ctrl.valid        = 1'b1;
          ctrl.jump         = 1'b1;
          ctrl.ex.link      = 1'b1;
          ctrl.ex.reg_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control for the 5-stage MIPS core.
// Decodes the ID opcode, detects load-use hazards, and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB.
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   id_valid, id_op              IF/ID contents (valid flag, opcode)
//   id_rs, id_rt, id_rd          register fields in ID
//   flush                        taken branch resolved in EX; kill ID
//   stall                        hold PC and IF/ID (combinational)
//   id_jump                      j/jal redirect from ID (combinational)
//   ex_*                         ID/EX controls and write register
//   mem_*                        EX/MEM controls and write register
//   wb_*                         MEM/WB controls and write register
module pipe_ctrl_unit
  import mips_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter bit EN_IMM   = 1'b1,
  parameter bit EN_BNE   = 1'b1,
  parameter bit EN_JAL   = 1'b1,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic              stall,
  output logic              id_jump,
  output logic              ex_alu_src,
  output logic              ex_branch,
  output logic              ex_branch_ne,
  output logic              ex_link,
  output logic [2:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic              mem_reg_write,
  output logic              mem_link,
  output logic [REG_AW-1:0] mem_dest,
  output logic              wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic              wb_link,
  output logic [REG_AW-1:0] wb_dest
);

  ctrl_t             id_ctrl;
  logic [REG_AW-1:0] id_dest;
  logic              hazard;
  logic              id_load;

  ex_ctrl_t          ex_q;
  logic [REG_AW-1:0] ex_dest_q;
  mem_ctrl_t         mem_q;
  logic [REG_AW-1:0] mem_dest_q;
  wb_ctrl_t          wb_q;
  logic [REG_AW-1:0] wb_dest_q;

  ctrl_decoder #(
    .EN_IMM (EN_IMM),
    .EN_BNE (EN_BNE),
    .EN_JAL (EN_JAL)
  ) u_decoder (
    .op   (id_op),
    .ctrl (id_ctrl)
  );

  // Unknown opcodes are bubbles, so their destination is 0 as well.
  always_comb begin
    if (!id_ctrl.valid)       id_dest = '0;
    else if (id_ctrl.ex.link) id_dest = REG_AW'(LINK_REG);
    else if (id_ctrl.reg_dst) id_dest = id_rd;
    else                      id_dest = id_rt;
  end

  // A load in EX whose target is needed in ID; $0 never causes a stall.
  assign hazard = ex_q.mem_read & id_valid & (ex_dest_q != '0) &
                  ((ex_dest_q == id_rs) |
                   ((ex_dest_q == id_rt) & id_ctrl.reads_rt));

  // A flush kills the ID instruction, so there is nothing left to hold.
  assign stall   = hazard & ~flush & ~reset;
  assign id_jump = id_valid & id_ctrl.jump & ~hazard & ~flush & ~reset;
  assign id_load = id_valid & ~stall & ~flush;

  // NOTE: pipeline state is updated with non-blocking assignments so every
  // stage samples its predecessor's pre-edge value; blocking assignments
  // here would let an instruction skip stages within one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= EX_BUBBLE;
      ex_dest_q  <= '0;
      mem_q      <= '0;
      mem_dest_q <= '0;
      wb_q       <= '0;
      wb_dest_q  <= '0;
    end else begin
      ex_q       <= id_load ? id_ctrl.ex : EX_BUBBLE;
      ex_dest_q  <= id_load ? id_dest    : '0;
      mem_q      <= '{mem_read:   ex_q.mem_read,
                      mem_write:  ex_q.mem_write,
                      mem_to_reg: ex_q.mem_to_reg,
                      reg_write:  ex_q.reg_write,
                      link:       ex_q.link};
      mem_dest_q <= ex_dest_q;
      wb_q       <= '{mem_to_reg: mem_q.mem_to_reg,
                      reg_write:  mem_q.reg_write,
                      link:       mem_q.link};
      wb_dest_q  <= mem_dest_q;
    end
  end

  assign ex_alu_src     = ex_q.alu_src;
  assign ex_branch      = ex_q.branch;
  assign ex_branch_ne   = ex_q.branch_ne;
  assign ex_link        = ex_q.link;
  assign ex_alu_op      = ex_q.alu_op;
  assign ex_dest        = ex_dest_q;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_mem_to_reg  = ex_q.mem_to_reg;
  assign ex_reg_write   = ex_q.reg_write;

  assign mem_mem_read   = mem_q.mem_read;
  assign mem_mem_write  = mem_q.mem_write;
  assign mem_mem_to_reg = mem_q.mem_to_reg;
  assign mem_reg_write  = mem_q.reg_write;
  assign mem_link       = mem_q.link;
  assign mem_dest       = mem_dest_q;

  assign wb_mem_to_reg  = wb_q.mem_to_reg;
  assign wb_reg_write   = wb_q.reg_write;
  assign wb_link        = wb_q.link;
  assign wb_dest        = wb_dest_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit. Two instances run on shared
// stimulus: index 0 with jal enabled, index 1 with jal disabled.
// A behavioural model (opcode table + three-slot pipeline) predicts outputs.
`timescale 1ns/1ps
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       flush;

  logic       stall [2];
  logic       id_jump [2];
  logic       ex_alu_src [2], ex_branch [2], ex_branch_ne [2], ex_link [2];
  logic [2:0] ex_alu_op [2];
  logic [4:0] ex_dest [2];
  logic       ex_mem_read [2], ex_mem_write [2], ex_mem_to_reg [2], ex_reg_write [2];
  logic       mem_mem_read [2], mem_mem_write [2], mem_mem_to_reg [2];
  logic       mem_reg_write [2], mem_link [2];
  logic [4:0] mem_dest [2];
  logic       wb_mem_to_reg [2], wb_reg_write [2], wb_link [2];
  logic [4:0] wb_dest [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_ctrl_unit #(
      .REG_AW   (5),
      .EN_IMM   (1'b1),
      .EN_BNE   (1'b1),
      .EN_JAL   (g == 0),
      .LINK_REG (31)
    ) dut (
      .clk            (clk),
      .reset          (reset),
      .id_valid       (id_valid),
      .id_op          (id_op),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_rd          (id_rd),
      .flush          (flush),
      .stall          (stall[g]),
      .id_jump        (id_jump[g]),
      .ex_alu_src     (ex_alu_src[g]),
      .ex_branch      (ex_branch[g]),
      .ex_branch_ne   (ex_branch_ne[g]),
      .ex_link        (ex_link[g]),
      .ex_alu_op      (ex_alu_op[g]),
      .ex_dest        (ex_dest[g]),
      .ex_mem_read    (ex_mem_read[g]),
      .ex_mem_write   (ex_mem_write[g]),
      .ex_mem_to_reg  (ex_mem_to_reg[g]),
      .ex_reg_write   (ex_reg_write[g]),
      .mem_mem_read   (mem_mem_read[g]),
      .mem_mem_write  (mem_mem_write[g]),
      .mem_mem_to_reg (mem_mem_to_reg[g]),
      .mem_reg_write  (mem_reg_write[g]),
      .mem_link       (mem_link[g]),
      .mem_dest       (mem_dest[g]),
      .wb_mem_to_reg  (wb_mem_to_reg[g]),
      .wb_reg_write   (wb_reg_write[g]),
      .wb_link        (wb_link[g]),
      .wb_dest        (wb_dest[g])
    );
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       alu_src, branch, branch_ne, link, jump, reads_rt;
    logic       mem_read, mem_write, mem_to_reg, reg_write;
    logic [2:0] alu_op;
    logic [4:0] dest;
  } m_inst_t;

  m_inst_t m_ex [2], m_mem [2], m_wb [2];

  // What one instruction means, written straight from the instruction table.
  function automatic m_inst_t m_decode(logic [5:0] op, logic [4:0] rt,
                                       logic [4:0] rd, bit en_jal);
    m_inst_t m = '0;
    case (op)
      6'd0:  begin m.reg_write = 1; m.alu_op = 3'd2; m.dest = rd; m.reads_rt = 1; end
      6'd35: begin m.alu_src = 1; m.mem_read = 1; m.mem_to_reg = 1;
                   m.reg_write = 1; m.dest = rt; end
      6'd43: begin m.alu_src = 1; m.mem_write = 1; m.dest = rt; m.reads_rt = 1; end
      6'd4:  begin m.branch = 1; m.alu_op = 3'd1; m.dest = rt; m.reads_rt = 1; end
      6'd5:  begin m.branch = 1; m.branch_ne = 1; m.alu_op = 3'd1; m.dest = rt;
                   m.reads_rt = 1; end
      6'd8:  begin m.alu_src = 1; m.reg_write = 1; m.alu_op = 3'd0; m.dest = rt; end
      6'd12: begin m.alu_src = 1; m.reg_write = 1; m.alu_op = 3'd3; m.dest = rt; end
      6'd13: begin m.alu_src = 1; m.reg_write = 1; m.alu_op = 3'd4; m.dest = rt; end
      6'd10: begin m.alu_src = 1; m.reg_write = 1; m.alu_op = 3'd5; m.dest = rt; end
      6'd2:  begin m.jump = 1; m.dest = rt; end
      6'd3:  if (en_jal) begin m.jump = 1; m.link = 1; m.reg_write = 1; m.dest = 5'd31; end
      default: ;
    endcase
    return m;
  endfunction

  function automatic bit m_stall(int k);
    m_inst_t d = m_decode(id_op, id_rt, id_rd, k == 0);
    if (reset || flush || !id_valid) return 0;
    if (!m_ex[k].mem_read || m_ex[k].dest == 5'd0) return 0;
    return (m_ex[k].dest == id_rs) || (m_ex[k].dest == id_rt && d.reads_rt);
  endfunction

  function automatic logic [35:0] exp_vec(int k);
    m_inst_t d = m_decode(id_op, id_rt, id_rd, k == 0);
    bit s = m_stall(k);
    bit j = !reset && id_valid && d.jump && !s && !flush;
    return {s, j,
            m_ex[k].alu_src, m_ex[k].branch, m_ex[k].branch_ne, m_ex[k].link,
            m_ex[k].alu_op, m_ex[k].dest,
            m_ex[k].mem_read, m_ex[k].mem_write, m_ex[k].mem_to_reg, m_ex[k].reg_write,
            m_mem[k].mem_read, m_mem[k].mem_write, m_mem[k].mem_to_reg,
            m_mem[k].reg_write, m_mem[k].link, m_mem[k].dest,
            m_wb[k].mem_to_reg, m_wb[k].reg_write, m_wb[k].link, m_wb[k].dest};
  endfunction

  function automatic logic [35:0] obs_vec(int k);
    return {stall[k], id_jump[k],
            ex_alu_src[k], ex_branch[k], ex_branch_ne[k], ex_link[k],
            ex_alu_op[k], ex_dest[k],
            ex_mem_read[k], ex_mem_write[k], ex_mem_to_reg[k], ex_reg_write[k],
            mem_mem_read[k], mem_mem_write[k], mem_mem_to_reg[k],
            mem_reg_write[k], mem_link[k], mem_dest[k],
            wb_mem_to_reg[k], wb_reg_write[k], wb_link[k], wb_dest[k]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(bit v, logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                       logic [4:0] rd, bit fl);
    id_valid = v; id_op = op; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
    #1;
  endtask

  // One clock edge; the model advances with the inputs held across the edge.
  task automatic tick();
    bit s [2];
    m_inst_t d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) s[k] = m_stall(k);
    for (int k = 0; k < 2; k++) begin
      d = m_decode(id_op, id_rt, id_rd, k == 0);
      if (reset) begin
        m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
      end else begin
        m_wb[k]  = m_mem[k];
        m_mem[k] = m_ex[k];
        m_ex[k]  = (id_valid && !s[k] && !flush) ? d : '0;
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1, 6'd0, 5'd1, 5'd2, 5'd3, 0);
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== 36'h0) begin
        errors++;
        $display("FAIL reset_state inst%0d: got %h expected %h", k, obs_vec(k), 36'h0);
      end
    end
    reset = 1'b0;
    drive(0, 6'd0, 5'd0, 5'd0, 5'd0, 0);
    tick();
  endtask

  task automatic test_r_type();
    drive(1, 6'd0, 5'd1, 5'd2, 5'd3, 0);
    tick();
    drive(0, 6'd0, 5'd0, 5'd0, 5'd0, 0);
    checks++;
    if ({ex_reg_write[0], ex_dest[0], ex_alu_op[0]} !== {1'b1, 5'd3, 3'b010}) begin
      errors++;
      $display("FAIL r_type_ex: got %b/%0d/%b expected 1/3/010",
               ex_reg_write[0], ex_dest[0], ex_alu_op[0]);
    end
    tick(); tick();
    checks++;
    if ({wb_reg_write[0], wb_dest[0]} !== {1'b1, 5'd3}) begin
      errors++;
      $display("FAIL r_type_wb: got %b/%0d expected 1/3", wb_reg_write[0], wb_dest[0]);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        errors++;
        $display("FAIL r_type_model inst%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_load_use();
    logic [35:0] v;
    // lw $5 ; add using $5 as rs
    drive(1, 6'd35, 5'd1, 5'd5, 5'd0, 0);
    tick();
    drive(1, 6'd0, 5'd5, 5'd6, 5'd7, 0);
    checks++;
    if (stall[0] !== 1'b1) begin
      errors++; $display("FAIL load_use_stall: got %b expected 1", stall[0]);
    end
    tick();
    v = obs_vec(0);
    checks++;
    if ({v[35], v[33:18]} !== 17'h0) begin
      errors++;
      $display("FAIL load_use_bubble: got stall=%b ex=%h expected 0/0000", v[35], v[33:18]);
    end
    tick();
    checks++;
    if ({ex_reg_write[0], ex_dest[0], stall[0]} !== {1'b1, 5'd7, 1'b0}) begin
      errors++;
      $display("FAIL load_use_resume: got %b/%0d/%b expected 1/7/0",
               ex_reg_write[0], ex_dest[0], stall[0]);
    end
    // lw $5 ; sw reading $5 through rt
    drive(1, 6'd35, 5'd1, 5'd5, 5'd0, 0);
    tick();
    drive(1, 6'd43, 5'd2, 5'd5, 5'd0, 0);
    checks++;
    if (stall[0] !== 1'b1) begin
      errors++; $display("FAIL load_sw_stall: got %b expected 1", stall[0]);
    end
    tick(); tick();
    // lw $0 ; add using $0 -> no stall
    drive(1, 6'd35, 5'd1, 5'd0, 5'd0, 0);
    tick();
    drive(1, 6'd0, 5'd0, 5'd0, 5'd4, 0);
    checks++;
    if (stall[0] !== 1'b0) begin
      errors++; $display("FAIL load_zero_stall: got %b expected 0", stall[0]);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        errors++;
        $display("FAIL load_use_model inst%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
      end
    end
    tick();
  endtask

  task automatic test_flush();
    logic [35:0] v;
    drive(1, 6'd4, 5'd1, 5'd2, 5'd0, 1);
    checks++;
    if ({stall[0], id_jump[0]} !== 2'b00) begin
      errors++; $display("FAIL flush_beq_comb: got %b%b expected 00", stall[0], id_jump[0]);
    end
    tick();
    v = obs_vec(0);
    checks++;
    if (v[33:18] !== 16'h0) begin
      errors++; $display("FAIL flush_beq_bubble: got %h expected 0000", v[33:18]);
    end
    drive(1, 6'd35, 5'd1, 5'd4, 5'd0, 0);
    tick();
    drive(1, 6'd0, 5'd4, 5'd1, 5'd2, 1);
    checks++;
    if (stall[0] !== 1'b0) begin
      errors++; $display("FAIL flush_hazard_stall: got %b expected 0", stall[0]);
    end
    tick();
    v = obs_vec(0);
    checks++;
    if (v[33:18] !== 16'h0) begin
      errors++; $display("FAIL flush_hazard_bubble: got %h expected 0000", v[33:18]);
    end
  endtask

  task automatic test_jal();
    logic [35:0] v;
    drive(1, 6'd3, 5'd0, 5'd0, 5'd0, 0);
    checks++;
    if ({id_jump[0], id_jump[1]} !== 2'b10) begin
      errors++; $display("FAIL jal_jump: got %b%b expected 10", id_jump[0], id_jump[1]);
    end
    tick();
    drive(0, 6'd0, 5'd0, 5'd0, 5'd0, 0);
    checks++;
    if ({ex_link[0], ex_dest[0], ex_reg_write[0]} !== {1'b1, 5'd31, 1'b1}) begin
      errors++;
      $display("FAIL jal_ex: got %b/%0d/%b expected 1/31/1",
               ex_link[0], ex_dest[0], ex_reg_write[0]);
    end
    v = obs_vec(1);
    checks++;
    if (v[33:18] !== 16'h0) begin
      errors++; $display("FAIL jal_disabled_ex: got %h expected 0000", v[33:18]);
    end
    tick();
  endtask

  task automatic test_imm();
    logic [5:0] ops [4] = '{6'd8, 6'd12, 6'd13, 6'd10};
    logic [2:0] alu [4] = '{3'b000, 3'b011, 3'b100, 3'b101};
    for (int i = 0; i < 4; i++) begin
      drive(1, ops[i], 5'd1, 5'(i + 8), 5'd0, 0);
      tick();
      checks++;
      if ({ex_alu_op[0], ex_alu_src[0], ex_dest[0]} !== {alu[i], 1'b1, 5'(i + 8)}) begin
        errors++;
        $display("FAIL imm_op%0d: got %b/%b/%0d expected %b/1/%0d", ops[i],
                 ex_alu_op[0], ex_alu_src[0], ex_dest[0], alu[i], i + 8);
      end
    end
  endtask

  task automatic test_reset_in_stall();
    drive(1, 6'd35, 5'd1, 5'd5, 5'd0, 0);
    tick();
    drive(1, 6'd0, 5'd5, 5'd6, 5'd7, 0);
    reset = 1'b1;
    #1;
    checks++;
    if (stall[0] !== 1'b0) begin
      errors++; $display("FAIL reset_stall_comb: got %b expected 0", stall[0]);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== 36'h0) begin
        errors++;
        $display("FAIL reset_stall_state inst%0d: got %h expected 0", k, obs_vec(k));
      end
    end
    reset = 1'b0;
    drive(0, 6'd0, 5'd0, 5'd0, 5'd0, 0);
    tick();
  endtask

  task automatic test_random();
    logic [5:0] pool [14] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd12,
                              6'd13, 6'd10, 6'd2, 6'd3, 6'd63, 6'd7, 6'd35};
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 9) != 0, pool[$urandom_range(0, 13)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL random_c%0d inst%0d: got %h expected %h", n, k,
                   obs_vec(k), exp_vec(k));
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
    end
    reset = 1'b1;
    id_valid = 0; id_op = '0; id_rs = '0; id_rt = '0; id_rd = '0; flush = 0;
    @(posedge clk); #1;
    test_reset();
    test_r_type();
    test_load_use();
    test_flush();
    test_jal();
    test_imm();
    test_reset_in_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Pipelined main control for the 5-stage MIPS core. Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards and applies stall and flush bubbles. Parametrised successor to the single-cycle main decoder, with an optional immediate-ALU, bne and jal instruction subset.

Parameters:
REG_AW, 5, register-address width
EN_IMM, 1, decode addi(001000)/andi(001100)/ori(001101)/slti(001010); 0 -> treated as unknown
EN_BNE, 1, decode bne(000101); 0 -> unknown
EN_JAL, 1, decode jal(000011); 0 -> unknown
LINK_REG, 31, destination register for jal

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
id_valid  in  1  IF/ID holds a real instruction
id_op  in  6  opcode field of the instruction in ID
id_rs, id_rt, id_rd  in  REG_AW  register fields in ID
flush  in  1  branch taken, resolved in EX; kill ID
stall  out  1  hold PC and IF/ID this cycle (combinational)
id_jump  out  1  j/jal decoded in ID and not stalled (combinational redirect)
ex_alu_src, ex_branch, ex_branch_ne, ex_link  out  1 each  ID/EX controls
ex_alu_op  out  3  000 add, 001 sub, 010 R-funct, 011 and, 100 or, 101 slt
ex_dest  out  REG_AW  write register: link ? LINK_REG : (reg_dst ? rd : rt)
ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  out  1 each
mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_link  out  1 each  EX/MEM
mem_dest  out  REG_AW
wb_mem_to_reg, wb_reg_write, wb_link  out  1 each  MEM/WB
wb_dest  out  REG_AW

Behaviour:
- Reset: all registered outputs 0 (a bubble in every stage). stall = 0 and id_jump = 0 while reset is high.
- Decode (combinational, ID):
  - R (000000): reg_dst, reg_write, alu_op=010.
  - lw: alu_src, mem_read, mem_to_reg, reg_write, op=000.
  - sw: alu_src, mem_write, op=000, no reg_write.
  - beq: branch, op=001. bne: branch, branch_ne, op=001.
  - addi/andi/ori/slti: alu_src, reg_write, op 000/011/100/101.
  - j: jump only. jal: jump, link, reg_write.
  - Unknown/disabled opcode: all zero (bubble, no trap).
- Bubble: all control bits and dest forced to 0.
- Load-use hazard: ex_mem_read & id_valid & ex_dest!=0 & (ex_dest==id_rs | (ex_dest==id_rt & ID op reads rt: R, sw, beq, bne)).
  - Hazard -> stall=1 and a bubble into ID/EX next edge; exactly one stall cycle per load-use pair.
- id_jump = id_valid & (j|jal) & ~stall & ~flush.
- ID/EX captures the decoded bundle when id_valid & ~stall & ~flush; otherwise a bubble.
- EX/MEM and MEM/WB always advance (never stalled); EX/MEM takes ID/EX, MEM/WB takes EX/MEM.
- flush and hazard in the same cycle: flush wins, stall=0, bubble into ID/EX.
- ex_dest = 0 with reg_write = 1 is legal: write to $0 is suppressed by the datapath. The unit does not hazard on $0.
- Reset mid-stream: all stages are bubbled on the next edge; there is no partial drain.
- Latency: a decoded instruction appears on ex_* 1 cycle after ID, on mem_* after 2 cycles, on wb_* after 3 cycles.

Decomposition:
- Shared package mips_ctrl_pkg: opcode localparams, ALU-op encodings, packed ctrl-bundle struct plus a BUBBLE constant.
- One sub-module: ctrl_decoder (the combinational opcode-to-bundle decode, parameter-gated), instanced once.
- Hazard logic and pipeline registers stay in the top level.

Test Plan:
- Reset held 2 cycles, then id_op=000000, rd=3, id_valid=1 -> ex_reg_write=1, ex_dest=3, ex_alu_op=010 after 1 clk; wb_reg_write=1, wb_dest=3 after 3 clks.
- lw rt=5 then add rs=5 -> stall=1 for exactly 1 cycle; ex_* all 0 for that cycle; add reaches EX on the following cycle.
- lw rt=5 then sw rt=5 -> stall; lw rt=0 then add rs=0 -> no stall.
- beq in ID with flush=1 in the same cycle -> ID/EX bubble, stall=0, id_jump=0; flush together with a load-use hazard -> stall=0.
- jal in ID (EN_JAL=1) -> id_jump=1; after 1 clk ex_link=1, ex_dest=31, ex_reg_write=1. With EN_JAL=0 -> id_jump=0 and ex_* all 0.
- addi/andi/ori/slti -> ex_alu_op 000/011/100/101 with alu_src=1. Assert reset during a stall -> every stage is a bubble next edge and stall=0.
